// File: rtl/stack_seq.sv
// Operand-stack sequencer: caches top-of-stack in a register, spills the rest to a
// single-port sync-read RAM, and feeds the external ALU for binary operations.
module stack_seq #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_aluop,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [AW-1:0]    mem_addr,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   output logic [WIDTH-1:0] tos,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty,
   output logic             done,
   output logic             err,
   output logic             err_sticky
);

   typedef enum logic [2:0] {IDLE, WR, RD, LD, ERR} state_t;

   localparam logic [1:0]  OP_PUSH  = 2'd0;
   localparam logic [1:0]  OP_POP   = 2'd1;
   localparam logic [1:0]  OP_BINOP = 2'd2;
   localparam logic [1:0]  OP_DUP   = 2'd3;
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_C    = (AW+1)'(1);
   localparam logic [AW:0] TWO_C    = (AW+1)'(2);

   state_t           state, state_nxt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic             accept;
   logic             legal;
   logic [AW-1:0]    addr_m1;
   logic [AW-1:0]    addr_m2;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign full      = (count == DEPTH_C);
   assign empty     = (count == '0);
   assign addr_m1   = AW'(count - ONE_C);
   assign addr_m2   = AW'(count - TWO_C);
   assign alu_a     = mem_rdata;
   assign alu_b     = tos;

   // Legality is judged on the count seen at accept; rejected commands leave state untouched.
   always_comb begin
      legal = 1'b0;
      case (cmd_op)
         OP_PUSH:  legal = !full;
         OP_POP:   legal = !empty;
         OP_BINOP: legal = (count >= TWO_C);
         OP_DUP:   legal = !empty && !full;
         default:  legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!legal)
                  state_nxt = ERR;
               else if (cmd_op == OP_PUSH || cmd_op == OP_DUP)
                  state_nxt = WR;
               else
                  state_nxt = RD;
            end
         end
         WR: begin
            // The old TOS spills to RAM only when the stack was non-empty.
            if (count != '0) begin
               mem_we    = 1'b1;
               mem_addr  = addr_m1;
               mem_wdata = tos;
            end
            done      = 1'b1;
            state_nxt = IDLE;
         end
         RD: begin
            if (count >= TWO_C) mem_addr = addr_m2;
            state_nxt = LD;
         end
         LD: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         ERR: begin
            done      = 1'b1;
            err       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         tos        <= '0;
         alu_op     <= '0;
         op_q       <= OP_PUSH;
         err_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q   <= cmd_op;
                  alu_op <= cmd_aluop;
               end
            end
            WR: begin
               count <= count + ONE_C;
               if (op_q == OP_PUSH) tos <= data_q;
            end
            LD: begin
               count <= count - ONE_C;
               // RAM read data is meaningful only when a second entry existed.
               if (op_q == OP_POP)
                  tos <= (count == ONE_C) ? '0 : mem_rdata;
               else
                  tos <= alu_y;
            end
            ERR: err_sticky <= 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) data_q <= cmd_data;
   end

endmodule

// File: tb/tb_stack_seq.sv
// Scoreboard bench for stack_seq: driver queues hand-computed expectations per command,
// a monitor checks them against done/err, latency, final tos/count and RAM writes.
module tb_stack_seq;

   localparam logic [1:0] PUSH  = 2'd0;
   localparam logic [1:0] POP   = 2'd1;
   localparam logic [1:0] BINOP = 2'd2;
   localparam logic [1:0] DUP   = 2'd3;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_aluop;
   logic [31:0] cmd_data;
   logic [3:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [31:0] tos;
   logic [4:0]  count;
   logic        full, empty, done, err, err_sticky;

   stack_seq #(.WIDTH(32), .DEPTH(16), .AW(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_aluop(cmd_aluop), .cmd_data(cmd_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
      .tos(tos), .count(count), .full(full), .empty(empty),
      .done(done), .err(err), .err_sticky(err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] ram [0:15];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   always_comb begin
      case (alu_op)
         4'd0:    alu_y = alu_a + alu_b;
         4'd1:    alu_y = alu_a - alu_b;
         4'd2:    alu_y = alu_a * alu_b;
         default: alu_y = alu_a ^ alu_b;
      endcase
   end

   typedef struct {
      logic        e_err;
      int          e_cyc;
      logic [31:0] e_tos;
      logic [4:0]  e_cnt;
   } exp_t;

   typedef struct {
      logic [3:0]  a;
      logic [31:0] d;
   } wr_t;

   exp_t exp_q[$];
   int   acc_q[$];
   wr_t  wr_q[$];
   int   checks = 0;
   int   errors = 0;
   logic pend = 1'b0;
   exp_t pend_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   task automatic issue(input logic [1:0] op, input logic [3:0] aop, input logic [31:0] d,
                        input logic e_err, input int e_cyc, input logic [31:0] e_tos,
                        input logic [4:0] e_cnt, input logic wr, input logic [3:0] wa,
                        input logic [31:0] wd);
      exp_t e;
      wr_t  w;
      int   n = 0;
      cmd_op    = op;
      cmd_aluop = aop;
      cmd_data  = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         timeout("cmd_ready_wait");
         cmd_valid = 1'b0;
         return;
      end
      e.e_err = e_err; e.e_cyc = e_cyc; e.e_tos = e_tos; e.e_cnt = e_cnt;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      if (wr) begin
         w.a = wa; w.d = wd;
         wr_q.push_back(w);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || pend || !cmd_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout("drain");
      @(negedge clk);
   endtask

   // Monitor: consumes expectations whenever the sequencer reports done or writes RAM.
   initial begin
      exp_t e;
      wr_t  w;
      int   a;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mem_we) begin
               if (wr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
               end else begin
                  w = wr_q.pop_front();
                  chk("wr_addr", 64'(mem_addr), 64'(w.a));
                  chk("wr_data", 64'(mem_wdata), 64'(w.d));
               end
            end
            if (done) begin
               if (exp_q.size() == 0 || acc_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got done=1 expected none");
               end else begin
                  e = exp_q.pop_front();
                  a = acc_q.pop_front();
                  chk("err", 64'(err), 64'(e.e_err));
                  chk("cycles", 64'(cyc - a + 1), 64'(e.e_cyc));
                  pend_e = e;
                  pend   = 1'b1;
               end
            end else if (pend) begin
               chk("tos", 64'(tos), 64'(pend_e.e_tos));
               chk("count", 64'(count), 64'(pend_e.e_cnt));
               pend = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = PUSH; cmd_aluop = 4'd0; cmd_data = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("ready_in_reset", 64'(cmd_ready), 64'd1);
      chk("done_in_reset", 64'(done), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_tos", 64'(tos), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      chk("rst_err_sticky", 64'(err_sticky), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);

      // PUSH 5, PUSH 7, BINOP add
      issue(PUSH,  4'd0, 32'd5, 1'b0, 2, 32'd5,  5'd1, 1'b0, 4'd0, 32'd0);
      issue(PUSH,  4'd0, 32'd7, 1'b0, 2, 32'd7,  5'd2, 1'b1, 4'd0, 32'd5);
      issue(BINOP, 4'd0, 32'd0, 1'b0, 3, 32'd12, 5'd1, 1'b0, 4'd0, 32'd0);
      issue(POP,   4'd0, 32'd0, 1'b0, 3, 32'd0,  5'd0, 1'b0, 4'd0, 32'd0);

      // PUSH 3, DUP, BINOP mul
      issue(PUSH,  4'd0, 32'd3, 1'b0, 2, 32'd3,  5'd1, 1'b0, 4'd0, 32'd0);
      issue(DUP,   4'd0, 32'd0, 1'b0, 2, 32'd3,  5'd2, 1'b1, 4'd0, 32'd3);
      issue(BINOP, 4'd2, 32'd0, 1'b0, 3, 32'd9,  5'd1, 1'b0, 4'd0, 32'd0);
      issue(POP,   4'd0, 32'd0, 1'b0, 3, 32'd0,  5'd0, 1'b0, 4'd0, 32'd0);
      drain();
      chk("sticky_clean", 64'(err_sticky), 64'd0);

      // Fill to DEPTH, then rejected PUSH and DUP
      for (int i = 1; i <= 16; i++)
         issue(PUSH, 4'd0, 32'(i), 1'b0, 2, 32'(i), 5'(i), (i > 1), 4'(i - 2), 32'(i - 1));
      drain();
      chk("full_flag", 64'(full), 64'd1);
      issue(PUSH, 4'd0, 32'd99, 1'b1, 2, 32'd16, 5'd16, 1'b0, 4'd0, 32'd0);
      issue(DUP,  4'd0, 32'd0,  1'b1, 2, 32'd16, 5'd16, 1'b0, 4'd0, 32'd0);
      for (int n = 15; n >= 0; n--)
         issue(POP, 4'd0, 32'd0, 1'b0, 3, 32'(n), 5'(n), 1'b0, 4'd0, 32'd0);
      drain();
      chk("empty_flag", 64'(empty), 64'd1);

      // Underflow errors
      issue(POP,   4'd0, 32'd0, 1'b1, 2, 32'd0, 5'd0, 1'b0, 4'd0, 32'd0);
      issue(PUSH,  4'd0, 32'd4, 1'b0, 2, 32'd4, 5'd1, 1'b0, 4'd0, 32'd0);
      issue(BINOP, 4'd0, 32'd0, 1'b1, 2, 32'd4, 5'd1, 1'b0, 4'd0, 32'd0);
      drain();
      chk("err_sticky_set", 64'(err_sticky), 64'd1);

      // Reset in the middle of a POP
      issue(PUSH, 4'd0, 32'd8, 1'b0, 2, 32'd8, 5'd2, 1'b1, 4'd0, 32'd4);
      issue(PUSH, 4'd0, 32'd9, 1'b0, 2, 32'd9, 5'd3, 1'b1, 4'd1, 32'd8);
      drain();
      cmd_op = POP; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      chk("in_rd_not_ready", 64'(cmd_ready), 64'd0);
      rst = 1'b1;
      #1;
      chk("abort_count", 64'(count), 64'd0);
      chk("abort_tos", 64'(tos), 64'd0);
      chk("abort_mem_we", 64'(mem_we), 64'd0);
      chk("abort_ready", 64'(cmd_ready), 64'd1);
      chk("abort_sticky", 64'(err_sticky), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      issue(PUSH, 4'd0, 32'd2, 1'b0, 2, 32'd2, 5'd1, 1'b0, 4'd0, 32'd0);
      drain();

      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
